// File: rtl/adc128s_fc.sv
// rtl/adc128s_fc.sv - ADC128S 8-channel 12-bit SPI A/D converter bench model (optional ADC128S_NOISE_EN adds LFSR dither)
module adc128s_fc #(
   parameter logic [2:0] CH_LFT   = 3'd0,
   parameter logic [2:0] CH_RGHT  = 3'd4,
   parameter logic [2:0] CH_STEER = 3'd5,
   parameter logic [2:0] CH_BATT  = 3'd6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [11:0] ld_cell_lft,
   input  logic [11:0] ld_cell_rght,
   input  logic [11:0] steerPot,
   input  logic [11:0] batt
);

   logic ss_d1, ss_d2, ss_d3;
   logic sclk_d1, sclk_d2, sclk_d3;
   logic mosi_d1, mosi_d2;
   logic ss_fall, ss_rise, sclk_rise, sclk_fall;

   // tx holds the bits still to be sent after the one currently on MISO
   logic [14:0] tx;
   // only command bits [13:11] matter; they are the 3rd..5th bits received
   logic [2:0]  rx;
   logic [2:0]  sel_ch;
   logic [4:0]  bit_cnt;
   logic        miso_r;
   logic [11:0] raw_val;
   logic [11:0] cap_val;

   // synchronize the SPI pins into clk, with a third stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_d1   <= 1'b1;
         ss_d2   <= 1'b1;
         ss_d3   <= 1'b1;
         sclk_d1 <= 1'b1;
         sclk_d2 <= 1'b1;
         sclk_d3 <= 1'b1;
         mosi_d1 <= 1'b0;
         mosi_d2 <= 1'b0;
      end else begin
         ss_d1   <= SS_n;
         ss_d2   <= ss_d1;
         ss_d3   <= ss_d2;
         sclk_d1 <= SCLK;
         sclk_d2 <= sclk_d1;
         sclk_d3 <= sclk_d2;
         mosi_d1 <= MOSI;
         mosi_d2 <= mosi_d1;
      end
   end

   assign ss_fall   = ss_d3 & ~ss_d2;
   assign ss_rise   = ~ss_d3 & ss_d2;
   assign sclk_rise = ~sclk_d3 & sclk_d2;
   assign sclk_fall = sclk_d3 & ~sclk_d2;

   // route the selected channel to the capture path; unmapped channels read zero
   always_comb begin
      raw_val = 12'h000;
      if (sel_ch == CH_LFT)
         raw_val = ld_cell_lft;
      else if (sel_ch == CH_RGHT)
         raw_val = ld_cell_rght;
      else if (sel_ch == CH_STEER)
         raw_val = steerPot;
      else if (sel_ch == CH_BATT)
         raw_val = batt;
   end

`ifdef ADC128S_NOISE_EN
   logic [7:0]  lfsr;
   logic [13:0] noisy;

   // dither LFSR steps once per frame start
   always_ff @(posedge clk) begin
      if (rst)
         lfsr <= 8'hA5;
      else if (ss_fall)
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   // add signed -2..+1 dither and clamp to the 12-bit range
   always_comb begin
      noisy = {2'b00, raw_val} + {{12{lfsr[1]}}, lfsr[1:0]};
      if (noisy[13])
         cap_val = 12'h000;
      else if (noisy[12])
         cap_val = 12'hFFF;
      else
         cap_val = noisy[11:0];
   end
`else
   assign cap_val = raw_val;
`endif

   // frame handling: SS_n edges take priority over SCLK edges in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         tx      <= 15'h0000;
         rx      <= 3'd0;
         sel_ch  <= 3'd0;
         bit_cnt <= 5'd0;
         miso_r  <= 1'b1;
      end else if (ss_fall) begin
         tx      <= {3'b000, cap_val};
         miso_r  <= 1'b0;
         bit_cnt <= 5'd0;
      end else if (ss_rise) begin
         if (bit_cnt == 5'd16)
            sel_ch <= rx;
         miso_r <= 1'b1;
      end else if (!ss_d2) begin
         if (sclk_rise) begin
            if (bit_cnt < 5'd5)
               rx <= {rx[1:0], mosi_d2};
            if (bit_cnt != 5'd16)
               bit_cnt <= bit_cnt + 5'd1;
         end else if (sclk_fall && bit_cnt != 5'd0) begin
            // the fall before the first rise keeps the MSB on the line
            miso_r <= tx[14];
            tx     <= {tx[13:0], 1'b0};
         end
      end
   end

   assign MISO = miso_r;

endmodule

// File: tb/tb_adc128s_fc.sv
// tb/tb_adc128s_fc.sv - scoreboard bench for adc128s_fc with random frames and a channel-level model
module tb_adc128s_fc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b1;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic [11:0] ld_cell_lft = 12'd0;
   logic [11:0] ld_cell_rght = 12'd0;
   logic [11:0] steerPot = 12'd0;
   logic [11:0] batt = 12'd0;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];
   logic [2:0]  model_sel = 3'd0;

   adc128s_fc dut (
      .clk          (clk),
      .rst          (rst),
      .SS_n         (SS_n),
      .SCLK         (SCLK),
      .MOSI         (MOSI),
      .MISO         (MISO),
      .ld_cell_lft  (ld_cell_lft),
      .ld_cell_rght (ld_cell_rght),
      .steerPot     (steerPot),
      .batt         (batt)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] chan_value(input logic [2:0] ch);
      logic [11:0] v [8];
      for (int k = 0; k < 8; k++) v[k] = 12'h000;
      v[0] = ld_cell_lft;
      v[4] = ld_cell_rght;
      v[5] = steerPot;
      v[6] = batt;
      return v[ch];
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // one SPI frame; nbits < 16 aborts, chg_bit >= 0 rewrites ld_cell_lft mid-frame
   task automatic frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                        input logic [11:0] chg_val, input bit do_rst);
      logic [15:0] exp_word;
      exp_word = {4'h0, chan_value(model_sel)};
      if (nbits >= 16) exp_q.push_back(exp_word);
      SS_n = 1'b0;
      wait_clk(8);
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = (i < 16) ? cmd[15 - i] : 1'($urandom);
         if (i == chg_bit) ld_cell_lft = chg_val;
         wait_clk(8);
         SCLK = 1'b1;
         wait_clk(8);
      end
      if (do_rst) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("miso_after_rst", {15'h0, MISO}, 16'h0001);
         model_sel = 3'd0;
         wait_clk(6);
      end else if (nbits >= 16) begin
         model_sel = cmd[13:11];
      end
      SS_n = 1'b1;
      wait_clk(10);
   endtask

   // monitor: deserialize the first 16 MISO bits of each frame and score full frames
   initial begin
      logic [15:0] word;
      logic [15:0] exp_word;
      int bits;
      forever begin
         @(negedge SS_n);
         bits = 0;
         word = 16'h0;
         while (SS_n == 1'b0) begin
            @(posedge SCLK or posedge SS_n);
            if (SS_n == 1'b0) begin
               if (bits < 16) word = {word[14:0], MISO};
               bits++;
            end
         end
         if (bits >= 16) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL frame_unexpected: got %h expected none", word);
            end else begin
               exp_word = exp_q.pop_front();
`ifdef ADC128S_NOISE_EN
               n_cmp++;
               if (word[15:12] != 4'h0 ||
                   int'(word[11:0]) < ((int'(exp_word[11:0]) < 2) ? 0 : int'(exp_word[11:0]) - 2) ||
                   int'(word[11:0]) > ((int'(exp_word[11:0]) > 4094) ? 4095 : int'(exp_word[11:0]) + 1)) begin
                  n_err++;
                  $display("FAIL frame_noisy: got %h expected %h -2..+1", word, exp_word);
               end
`else
               check("frame", word, exp_word);
`endif
            end
         end
      end
   end

   initial begin
      logic [2:0] ch;
      int nb;
      rst = 1'b1;
      wait_clk(4);
      check("reset_miso", {15'h0, MISO}, 16'h0001);
      rst = 1'b0;
      wait_clk(4);

      ld_cell_lft = 12'd330;
      ld_cell_rght = 12'd320;
      steerPot = 12'h800;
      batt = 12'hFFF;
      frame(16'h2000, 16, -1, 12'h0, 1'b0);   // returns ch0 = 0x14A
      frame(16'h2800, 16, -1, 12'h0, 1'b0);   // returns ch4 = 0x140
      frame(16'h3000, 16, -1, 12'h0, 1'b0);   // returns ch5 = 0x800
      frame(16'h1000, 16, -1, 12'h0, 1'b0);   // returns ch6 = 0xFFF
      frame(16'h2800, 16, -1, 12'h0, 1'b0);   // returns ch2 = 0x000
      frame(16'h3000, 10, -1, 12'h0, 1'b0);   // aborted, stays ch5
      frame(16'h0000, 16, -1, 12'h0, 1'b0);   // returns ch5 = 0x800
      frame(16'h0000, 16, 5, 12'd100, 1'b0);  // ch0 captured as 0x14A
      frame(16'h0000, 17, -1, 12'h0, 1'b0);   // ch0 now 0x064, extra clock

      for (int r = 0; r < 20; r++) begin
         ch = 3'($urandom_range(0, 7));
         ld_cell_lft = 12'($urandom);
         ld_cell_rght = 12'($urandom);
         steerPot = 12'($urandom);
         batt = (r % 5 == 0) ? 12'hFFF : 12'($urandom);
         if (r % 7 == 3) ld_cell_lft = 12'h000;
         nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 15)) : int'($urandom_range(16, 18));
         frame({2'($urandom), ch, 11'($urandom)}, nb, -1, 12'h0, 1'b0);
      end

      frame(16'h3000, 8, -1, 12'h0, 1'b1);    // reset during bit 8
      frame(16'h2000, 16, -1, 12'h0, 1'b0);   // returns ch0
      frame(16'h0000, 16, -1, 12'h0, 1'b0);   // returns ch4

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adc128s_fc.md
Name: adc128s_fc

Overview:
- Cycle-based behavioural model of an ADC128S 8-channel, 12-bit SPI A/D converter, used as a bench-side support block for the Segway top-level.
- Presents four 12-bit analog values (left load cell, right load cell, steering pot, battery) on fixed channels.
- Serves them over a 4-wire SPI slave interface.
- Runs on the system clock and oversamples the SPI pins.

Parameters:
- CH_LFT, 3'd0: channel number returning ld_cell_lft.
- CH_RGHT, 3'd4: channel number returning ld_cell_rght.
- CH_STEER, 3'd5: channel number returning steerPot.
- CH_BATT, 3'd6: channel number returning batt.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- SS_n  in  1  SPI slave select, active low.
- SCLK  in  1  SPI clock from master; idles high.
- MOSI  in  1  SPI command data from master.
- MISO  out  1  SPI conversion data to master.
- ld_cell_lft  in  12  analog value for CH_LFT.
- ld_cell_rght  in  12  analog value for CH_RGHT.
- steerPot  in  12  analog value for CH_STEER.
- batt  in  12  analog value for CH_BATT.

Behaviour:
- Interface is fixed: one clock domain (clk); reset is synchronous and active-high (rst).
- SS_n, SCLK and MOSI each pass through a 2-flop synchronizer in the clk domain.
- A third flop on SS_n and SCLK provides edge detection.
- Master timing requirement: each SCLK phase is held at least 4 clk cycles; SS_n falls at least 4 clk before the first SCLK fall.
- Reset state: shift register 0, selected channel 0, bit count 0, MISO 1.
- Transaction = one SS_n low period of 16 SCLK cycles, mode 0 style:
  - MOSI is sampled on the synchronized SCLK rise.
  - MISO advances on the synchronized SCLK fall.
- Pipelined protocol: the command word in transaction N selects the channel returned in transaction N+1.
  - After reset, the first transaction returns the channel-0 value.
- On SS_n fall (synchronized):
  - Capture the value of the currently selected channel into the output shift register as {4'b0, value[11:0]}.
  - Clear the bit counter.
  - MISO immediately presents bit 15.
- Channel mapping: ld_cell_lft, ld_cell_rght, steerPot or batt per the CH_* parameters; any other channel returns 12'h000.
- SCLK rise with SS_n low: shift MOSI into the receive register LSB-first-in (MSB arrives first); increment the bit counter, saturating at 16.
- SCLK fall with SS_n low: shift the output register left by one, filling with 0; MISO = register[15].
  - Exception: the SCLK fall preceding the first rise (counter 0) does not shift, so MSB stays valid for the first rise.
- On SS_n rise:
  - If the bit counter == 16, selected channel <= receive[13:11]; otherwise the channel is unchanged (aborted frame).
  - MISO returns to 1.
- Extra SCLK cycles beyond 16 shift out zeros and do not change the latched command (first 16 bits win; receive register stops shifting at count 16).
- Analog inputs may change at any time; only the value at the SS_n fall is returned. There is no mid-frame tearing.
- SS_n and SCLK toggling in the same clk cycle: SS_n handling takes priority and the SCLK edge is ignored.
- Reset asserted mid-transaction: abort immediately to the reset state; the next frame returns channel 0.

Optional Feature:
- Macro: ADC128S_NOISE_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (seed 8'hA5 on reset, taps 8,6,5,4) advances once per SS_n fall.
  - Its low 2 bits, interpreted as signed (-2..+1), are added to the captured 12-bit value.
  - The result saturates to 0..4095.
- Undefined: captured values are exact and no LFSR logic exists.

Test Plan:
- Reset, then frame 1 with MOSI command 16'h2000 (channel 4, ld_cell_lft=330): MISO returns 16'h014A (channel 0). Frame 2 with ld_cell_rght=320 returns 16'h0140.
- Command channel 5 then 6 with steerPot=12'h800 and batt=12'hFFF: frames return 16'h0800, then 16'h0FFF.
- Command channel 2 (unmapped): the following frame returns 16'h0000.
- Aborted frame: select channel 5; send only 10 SCLK cycles carrying command channel 6; raise SS_n. The next full frame still returns steerPot and the channel stays 5.
- Change ld_cell_lft from 330 to 100 mid-frame: the current frame still returns 16'h014A; the next channel-0 frame returns 16'h0064.
- Assert rst during bit 8 of a frame: MISO=1 next clk; the following frame returns the channel-0 value. With ADC128S_NOISE_EN, returned values stay within −2..+1 of the input.
